deparser_meta_strip: RTL
========================

// Module: deparser_meta_strip
// PURPOSE
//  Egress counterpart of the UniMon parser: consumes the {metadata words, packet words} stream the parser emits,
//  strips all metadata words, optionally rewrites DMAC/SMAC in the packet head from metadata, drops packets
//  flagged for drop, and forwards bare 134b packet words downstream. Sits between pipeline action stages and TX.
// PARAMETERS
//  MAC_META_IDX   1   index (0-based, in arrival order) of the meta word carrying {dmac,smac,ctrl}
//  OFIFO_DEPTH    4   output FIFO entries (power of 2, >=4)
//  READY_THRESH   2   ready_out deasserts when OFIFO occupancy >= READY_THRESH
// PORTS
//  clk                 in   1    clock
//  reset               in   1    synchronous, active-high reset
//  metadata_in_valid   in   1    input word valid
//  metadata_in         in   134  [133:132] tag, [131:0] payload
//  ready_out           out  1    may accept input (registered)
//  metadata_out_valid  out  1    output word valid
//  metadata_out        out  134  packet word, same tag format
//  ready_in            in   1    downstream accepts metadata_out this cycle
//  pkt_drop_cnt        out  32   packets dropped by ctrl[1]
//  err_cnt             out  32   packets arriving without metadata
// BEHAVIOUR
//  Tags: meta = 2'b11 (non-last) / 2'b00 (last meta); packet = 2'b01 head, 2'b11 body, 2'b10 tail; meaning set by state.
//  One clock, reset synchronous active-high: ready_out=1, metadata_out_valid=0, metadata_out=0, counters=0,
//   OFIFO flushed, FSM->IDLE, captured meta cleared. Reset mid-packet discards partial packet; next word
//   accepted after reset is treated as start of a new stream.
//  Word accepted iff metadata_in_valid && ready_out. Words with valid while ready_out=0 are a protocol error by
//   upstream and are ignored.
//  FSM: IDLE -> META on accepted tag 11 (meta_idx=0 this word); IDLE -> META_DONE on tag 00 (single meta word);
//   IDLE -> PKT on tag 01 (no meta: err_cnt+1, forward unmodified, rewrite/drop off); IDLE ignores tag 10.
//   META: meta_idx++ per word; word with meta_idx==MAC_META_IDX latched as {dmac=[127:80], smac=[79:32],
//   ctrl=[31:0]}; tag 00 -> META_DONE. META_DONE: waits for tag 01, any other tag ignored.
//   On head (01) from META_DONE -> PKT (or DROP if ctrl[1]). PKT/DROP: tag 10 -> IDLE, clears latched meta.
//   Packet of a single word is illegal; a 01 seen in PKT is treated as a new head without tail (err_cnt+1).
//  If MAC_META_IDX word never arrives before tag 00, ctrl treated as 0.
//  Rewrite: ctrl[0]=1 -> head word [127:80]<=dmac, [79:32]<=smac; all other bits/words untouched.
//  Drop: ctrl[1]=1 -> no word of that packet written to OFIFO; pkt_drop_cnt+1 at tail; ctrl[1] dominates ctrl[0].
//  Meta words never appear on metadata_out.
//  Pipeline: accepted word registered once (rewrite stage), written to OFIFO next cycle; OFIFO is show-ahead,
//   output registered. Latency input accept cycle N -> metadata_out_valid at N+2 when OFIFO empty and ready_in=1.
//  Output: metadata_out/metadata_out_valid held stable while valid && !ready_in; pop on valid && ready_in.
//  ready_out <= (occupancy_next < READY_THRESH); one-cycle lag absorbed by OFIFO headroom; OFIFO never overflows.
//  Simultaneous push and pop keeps occupancy; empty OFIFO -> valid=0; full never reached with defaults.
//  Counters saturate at 32'hFFFF_FFFF (no wrap).
// TESTING
//  T1 meta {11,00 (idx1: dmac=0A..,smac=0B..,ctrl=1)}, pkt 01,11,10, ready_in=1 -> 3 words out, head
//     [127:80]=dmac, [79:32]=smac, first valid 2 cycles after head accepted; no meta words out.
//  T2 same with ctrl=2'b11 -> no output words, pkt_drop_cnt=1, ready_out stays 1.
//  T3 ctrl=0 -> packet out bit-exact to input; 100 back-to-back packets, random ready_in -> order and
//     content preserved, no word lost/duplicated.
//  T4 ready_in=0 for 20 cycles during 8-word packet -> ready_out low once occupancy>=2, OFIFO <=4,
//     metadata_out stable; release -> remaining words drain in order.
//  T5 packet 01..10 with no meta -> forwarded unmodified, err_cnt=1.
//  T6 reset asserted mid-PKT for 1 cycle -> outputs at reset values next cycle; following full packet
//     processed correctly, partial packet never emitted.

Source files
------------

// File: rtl/deparser_meta_strip_if.sv
// Stream bundle between the action pipeline and TX: upstream word input and downstream packet output.
// The slave modport is the deparser side and the master modport is the environment side.
interface deparser_meta_strip_if;
  logic         metadata_in_valid;
  logic [133:0] metadata_in;
  logic         ready_out;
  logic         metadata_out_valid;
  logic [133:0] metadata_out;
  logic         ready_in;

  modport slave (
    input  metadata_in_valid, metadata_in, ready_in,
    output ready_out, metadata_out_valid, metadata_out
  );

  modport master (
    output metadata_in_valid, metadata_in, ready_in,
    input  ready_out, metadata_out_valid, metadata_out
  );
endinterface

// File: rtl/deparser_meta_strip.sv
// Strips metadata words, rewrites the head MACs or drops the packet as ctrl says, and queues packet words for TX.
// Latency: accept -> valid 2 cycles with an empty queue. ready_out deasserts as the queue reaches READY_THRESH.
module deparser_meta_strip #(
  parameter int MAC_META_IDX = 1,
  parameter int OFIFO_DEPTH  = 4,
  parameter int READY_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  deparser_meta_strip_if.slave bus,
  output logic [31:0]          pkt_drop_cnt,
  output logic [31:0]          err_cnt
);
  localparam int AW = $clog2(OFIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [7:0]  LP_MAC_IDX = 8'(MAC_META_IDX);
  localparam logic [CW-1:0] LP_THRESH = CW'(READY_THRESH);

  typedef enum logic [2:0] {S_IDLE, S_META, S_META_DONE, S_PKT, S_DROP} state_t;

  state_t         r_state, w_state_nxt;
  logic [7:0]     r_meta_idx, w_idx_nxt;
  logic [47:0]    r_dmac, r_smac, w_dmac_nxt, w_smac_nxt;
  logic [1:0]     r_ctrl, w_ctrl_nxt;
  logic           r_ready_out;
  logic           r_s1_vld;
  logic [133:0]   r_s1_dat;
  logic [133:0]   r_mem [OFIFO_DEPTH];
  logic [AW-1:0]  r_wr_ptr, r_rd_ptr, w_rd_nxt;
  logic [CW-1:0]  r_cnt, w_cnt_nxt, w_remain;
  logic           r_out_vld;
  logic [133:0]   r_out_dat, w_head_nxt;
  logic [31:0]    r_drop_cnt, r_err_cnt;

  logic         w_acc, w_fwd, w_rewrite, w_err_inc, w_drop_inc, w_push, w_pop;
  logic [1:0]   w_tag;
  logic [133:0] w_fwd_dat;

  assign w_acc = bus.metadata_in_valid && r_ready_out;
  assign w_tag = bus.metadata_in[133:132];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_meta_idx;
    w_dmac_nxt  = r_dmac;
    w_smac_nxt  = r_smac;
    w_ctrl_nxt  = r_ctrl;
    w_fwd       = 1'b0;
    w_rewrite   = 1'b0;
    w_err_inc   = 1'b0;
    w_drop_inc  = 1'b0;
    if (w_acc) begin
      case (r_state)
        S_IDLE: begin
          if (w_tag == 2'b11 || w_tag == 2'b00) begin
            // New meta block: stale fields cleared so a missing MAC word reads as ctrl=0.
            w_state_nxt = (w_tag == 2'b11) ? S_META : S_META_DONE;
            w_idx_nxt   = 8'd1;
            w_dmac_nxt  = '0;
            w_smac_nxt  = '0;
            w_ctrl_nxt  = '0;
            if (LP_MAC_IDX == 8'd0) begin
              w_dmac_nxt = bus.metadata_in[127:80];
              w_smac_nxt = bus.metadata_in[79:32];
              w_ctrl_nxt = bus.metadata_in[1:0];
            end
          end else if (w_tag == 2'b01) begin
            w_state_nxt = S_PKT;
            w_err_inc   = 1'b1;
            w_fwd       = 1'b1;
          end
        end
        S_META: begin
          if (w_tag == 2'b11 || w_tag == 2'b00) begin
            if (r_meta_idx == LP_MAC_IDX) begin
              w_dmac_nxt = bus.metadata_in[127:80];
              w_smac_nxt = bus.metadata_in[79:32];
              w_ctrl_nxt = bus.metadata_in[1:0];
            end
            if (r_meta_idx != 8'hFF) w_idx_nxt = r_meta_idx + 8'd1;
            if (w_tag == 2'b00) w_state_nxt = S_META_DONE;
          end
        end
        S_META_DONE: begin
          if (w_tag == 2'b01) begin
            w_state_nxt = r_ctrl[1] ? S_DROP : S_PKT;
            w_fwd       = !r_ctrl[1];
            w_rewrite   = r_ctrl[0];
          end
        end
        S_PKT: begin
          if (w_tag != 2'b00) w_fwd = 1'b1;
          if (w_tag == 2'b10 || w_tag == 2'b01) begin
            // Tail closes the packet; a repeated head starts a bare packet with no meta.
            w_state_nxt = (w_tag == 2'b10) ? S_IDLE : S_PKT;
            w_err_inc   = (w_tag == 2'b01);
            w_idx_nxt   = '0;
            w_dmac_nxt  = '0;
            w_smac_nxt  = '0;
            w_ctrl_nxt  = '0;
          end
        end
        S_DROP: begin
          if (w_tag == 2'b10) begin
            w_state_nxt = S_IDLE;
            w_drop_inc  = 1'b1;
            w_idx_nxt   = '0;
            w_dmac_nxt  = '0;
            w_smac_nxt  = '0;
            w_ctrl_nxt  = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_fwd_dat = bus.metadata_in;
    if (w_rewrite) begin
      w_fwd_dat[127:80] = r_dmac;
      w_fwd_dat[79:32]  = r_smac;
    end
  end

  // Output register always holds the queue head, so occupancy includes the word being presented.
  assign w_push     = r_s1_vld;
  assign w_pop      = r_out_vld && bus.ready_in;
  assign w_remain   = r_cnt - {{AW{1'b0}}, w_pop};
  assign w_cnt_nxt  = w_remain + {{AW{1'b0}}, w_push};
  assign w_rd_nxt   = r_rd_ptr + {{(AW-1){1'b0}}, w_pop};
  assign w_head_nxt = (w_remain == '0) ? r_s1_dat : r_mem[w_rd_nxt];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= r_s1_dat;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_meta_idx  <= '0;
      r_dmac      <= '0;
      r_smac      <= '0;
      r_ctrl      <= '0;
      r_ready_out <= 1'b1;
      r_s1_vld    <= 1'b0;
      r_s1_dat    <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_cnt       <= '0;
      r_out_vld   <= 1'b0;
      r_out_dat   <= '0;
      r_drop_cnt  <= '0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_meta_idx  <= w_idx_nxt;
      r_dmac      <= w_dmac_nxt;
      r_smac      <= w_smac_nxt;
      r_ctrl      <= w_ctrl_nxt;
      r_s1_vld    <= w_fwd;
      if (w_fwd) r_s1_dat <= w_fwd_dat;
      if (w_push) r_wr_ptr <= r_wr_ptr + {{(AW-1){1'b0}}, 1'b1};
      r_rd_ptr    <= w_rd_nxt;
      r_cnt       <= w_cnt_nxt;
      r_ready_out <= (w_cnt_nxt < LP_THRESH);
      r_out_vld   <= (w_cnt_nxt != '0);
      if (w_cnt_nxt != '0) r_out_dat <= w_head_nxt;
      if (w_drop_inc && r_drop_cnt != 32'hFFFF_FFFF) r_drop_cnt <= r_drop_cnt + 32'd1;
      if (w_err_inc && r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
    end
  end

  assign bus.ready_out          = r_ready_out;
  assign bus.metadata_out_valid = r_out_vld;
  assign bus.metadata_out       = r_out_dat;
  assign pkt_drop_cnt           = r_drop_cnt;
  assign err_cnt                = r_err_cnt;
endmodule
